// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   REG_W    : width of a register-number field
//   REG_ZERO : register $zero, never a real load destination
//   state_e  : controller FSM states
package pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    RELEASE  = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives the ID/EX status and mdu_done, receives the controls
//   slave  : controller side, receives the status, drives the controls and the debug outputs
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_is_mdu;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             ex_branch_taken;
  logic             mdu_done;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             mdu_start;
  logic [CNT_W-1:0] stall_count;
  logic             mdu_timeout;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_is_mdu,
           ex_mem_read, ex_rt, ex_branch_taken, mdu_done,
    input  pc_write, ifid_write, ifid_flush, idex_bubble,
           mdu_start, stall_count, mdu_timeout
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_mdu,
           ex_mem_read, ex_rt, ex_branch_taken, mdu_done,
    output pc_write, ifid_write, ifid_flush, idex_bubble,
           mdu_start, stall_count, mdu_timeout
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_lu.sv
// Load-use comparator: flags an ID instruction that reads the register
// a load currently in EX is about to write.
//   inputs : ID source fields + use flags, EX load flag + destination
//   lu_o   : stall required this cycle
module lu_hazard_cmp
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  output logic             lu_o
);

  // $zero is hardwired, so a load targeting it creates no dependency.
  assign lu_o = ex_mem_read_i & (ex_rt_i != REG_ZERO) &
                ((id_use_rs_i & (id_rs_i == ex_rt_i)) |
                 (id_use_rt_i & (id_rt_i == ex_rt_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the five-stage pipeline. Drives PC, IF/ID and
// ID/EX enables, flushes and bubbles; sequences multi-cycle MDU operations.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of pipeline_hazard_ctrl_if (status in, controls out,
//                saturating stall_count and sticky mdu_timeout)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; branch flush, load-use bubble or MDU launch
// MDU_WAIT | front end held until mdu_done or the wait limit expires
// RELEASE  | one cycle letting the held MDU instruction advance to EX
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipeline_hazard_ctrl_if.slave   bus
);

  localparam int WAIT_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic lu;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, mdu_start;

  lu_hazard_cmp u_lu (
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .id_use_rs_i   (bus.id_use_rs),
    .id_use_rt_i   (bus.id_use_rt),
    .ex_mem_read_i (bus.ex_mem_read),
    .ex_rt_i       (bus.ex_rt),
    .lu_o          (lu)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    mdu_start   = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.ex_branch_taken) begin
          // ID instruction is squashed, so its hazards do not matter.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (lu) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (bus.id_is_mdu) begin
          mdu_start   = 1'b1;
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_d     = MDU_WAIT;
          wait_cnt_d  = '0;
        end
      end
      MDU_WAIT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        // done has priority so a late-but-valid result is not flagged.
        if (bus.mdu_done) begin
          state_d = RELEASE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = RUN;
      default: state_d = RUN;
    endcase

    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      mdu_start   = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.mdu_start   = mdu_start;
  assign bus.stall_count = stall_cnt_q;
  assign bus.mdu_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=4, MDU_TIMEOUT=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(4)) bus ();

  pipeline_hazard_ctrl #(.CNT_W(4), .MDU_TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic quiet();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
    bus.id_is_mdu = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rt = '0;
    bus.ex_branch_taken = 1'b0; bus.mdu_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    quiet();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    quiet();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom);
      bus.id_use_rs = 1'($urandom); bus.id_use_rt = 1'($urandom);
      bus.id_is_mdu = 1'($urandom); bus.ex_mem_read = 1'($urandom);
      bus.ex_rt = 5'($urandom); bus.ex_branch_taken = 1'($urandom);
      bus.mdu_done = 1'($urandom);
      @(negedge clk);
      n_chk++; if (bus.pc_write !== 1'b0) begin n_fail++; $display("FAIL rst_pc_write got %b exp 0", bus.pc_write); end
      n_chk++; if (bus.idex_bubble !== 1'b1) begin n_fail++; $display("FAIL rst_bubble got %b exp 1", bus.idex_bubble); end
      n_chk++; if (bus.ifid_flush !== 1'b1) begin n_fail++; $display("FAIL rst_flush got %b exp 1", bus.ifid_flush); end
      n_chk++; if (bus.mdu_start !== 1'b0) begin n_fail++; $display("FAIL rst_mdu_start got %b exp 0", bus.mdu_start); end
      n_chk++; if (bus.stall_count !== 4'd0) begin n_fail++; $display("FAIL rst_stall_count got %0d exp 0", bus.stall_count); end
      tick();
    end
    quiet();
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL rel_pc_write got %b exp 1", bus.pc_write); end
    n_chk++; if (bus.ifid_flush !== 1'b0) begin n_fail++; $display("FAIL rel_flush got %b exp 0", bus.ifid_flush); end
    n_chk++; if (bus.mdu_timeout !== 1'b0) begin n_fail++; $display("FAIL rel_timeout got %b exp 0", bus.mdu_timeout); end
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8; bus.id_use_rs = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.pc_write !== 1'b0) begin n_fail++; $display("FAIL lu_pc_write got %b exp 0", bus.pc_write); end
    n_chk++; if (bus.ifid_write !== 1'b0) begin n_fail++; $display("FAIL lu_ifid_write got %b exp 0", bus.ifid_write); end
    n_chk++; if (bus.idex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble got %b exp 1", bus.idex_bubble); end
    n_chk++; if (bus.mdu_start !== 1'b0) begin n_fail++; $display("FAIL lu_mdu_start got %b exp 0", bus.mdu_start); end
    tick();
    quiet();
    @(negedge clk);
    n_chk++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_after_pc_write got %b exp 1", bus.pc_write); end
    n_chk++; if (bus.idex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_after_bubble got %b exp 0", bus.idex_bubble); end
    n_chk++; if (bus.stall_count !== 4'd1) begin n_fail++; $display("FAIL lu_stall_count got %0d exp 1", bus.stall_count); end
    tick();
    // load to $zero: no dependency
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_use_rs = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_zero_pc_write got %b exp 1", bus.pc_write); end
    n_chk++; if (bus.idex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_zero_bubble got %b exp 0", bus.idex_bubble); end
    tick();
    // rt match with use flag
    bus.ex_rt = 5'd17; bus.id_rs = 5'd3; bus.id_rt = 5'd17; bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.pc_write !== 1'b0) begin n_fail++; $display("FAIL lu_rt_pc_write got %b exp 0", bus.pc_write); end
    tick();
    // rs match but rs not read
    bus.id_rs = 5'd17; bus.id_rt = 5'd4; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_nouse_pc_write got %b exp 1", bus.pc_write); end
    // load flag low
    bus.ex_mem_read = 1'b0; bus.id_rt = 5'd17;
    @(negedge clk);
    n_chk++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_noload_pc_write got %b exp 1", bus.pc_write); end
    tick();
    quiet();
    @(negedge clk);
    n_chk++; if (bus.stall_count !== 4'd2) begin n_fail++; $display("FAIL lu_total_stall got %0d exp 2", bus.stall_count); end
    tick();
  endtask

  task automatic test_branch();
    apply_reset();
    bus.ex_branch_taken = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8;
    bus.id_rs = 5'd8; bus.id_use_rs = 1'b1; bus.id_is_mdu = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.ifid_flush !== 1'b1) begin n_fail++; $display("FAIL br_flush got %b exp 1", bus.ifid_flush); end
    n_chk++; if (bus.idex_bubble !== 1'b1) begin n_fail++; $display("FAIL br_bubble got %b exp 1", bus.idex_bubble); end
    n_chk++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL br_pc_write got %b exp 1", bus.pc_write); end
    n_chk++; if (bus.ifid_write !== 1'b1) begin n_fail++; $display("FAIL br_ifid_write got %b exp 1", bus.ifid_write); end
    n_chk++; if (bus.mdu_start !== 1'b0) begin n_fail++; $display("FAIL br_mdu_start got %b exp 0", bus.mdu_start); end
    tick();
    quiet();
    @(negedge clk);
    n_chk++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL br_after_pc_write got %b exp 1", bus.pc_write); end
    n_chk++; if (bus.stall_count !== 4'd0) begin n_fail++; $display("FAIL br_stall_count got %0d exp 0", bus.stall_count); end
    tick();
  endtask

  task automatic test_mdu();
    int starts;
    apply_reset();
    bus.id_is_mdu = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.mdu_start !== 1'b1) begin n_fail++; $display("FAIL mdu_launch_start got %b exp 1", bus.mdu_start); end
    n_chk++; if (bus.pc_write !== 1'b0) begin n_fail++; $display("FAIL mdu_launch_pc_write got %b exp 0", bus.pc_write); end
    n_chk++; if (bus.idex_bubble !== 1'b1) begin n_fail++; $display("FAIL mdu_launch_bubble got %b exp 1", bus.idex_bubble); end
    tick();
    starts = 0;
    for (int i = 1; i <= 5; i++) begin
      bus.mdu_done = (i == 5);
      bus.ex_branch_taken = (i == 2);
      @(negedge clk);
      if (bus.mdu_start === 1'b1) starts++;
      n_chk++; if (bus.pc_write !== 1'b0) begin n_fail++; $display("FAIL mdu_wait%0d_pc_write got %b exp 0", i, bus.pc_write); end
      n_chk++; if (bus.ifid_flush !== 1'b0) begin n_fail++; $display("FAIL mdu_wait%0d_flush got %b exp 0", i, bus.ifid_flush); end
      tick();
    end
    n_chk++; if (starts !== 0) begin n_fail++; $display("FAIL mdu_wait_starts got %0d exp 0", starts); end
    bus.mdu_done = 1'b0; bus.ex_branch_taken = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL mdu_rel_pc_write got %b exp 1", bus.pc_write); end
    n_chk++; if (bus.mdu_start !== 1'b0) begin n_fail++; $display("FAIL mdu_rel_start got %b exp 0", bus.mdu_start); end
    n_chk++; if (bus.idex_bubble !== 1'b0) begin n_fail++; $display("FAIL mdu_rel_bubble got %b exp 0", bus.idex_bubble); end
    n_chk++; if (bus.stall_count !== 4'd6) begin n_fail++; $display("FAIL mdu_rel_stall got %0d exp 6", bus.stall_count); end
    tick();
    bus.id_is_mdu = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL mdu_post_pc_write got %b exp 1", bus.pc_write); end
    n_chk++; if (bus.mdu_timeout !== 1'b0) begin n_fail++; $display("FAIL mdu_post_timeout got %b exp 0", bus.mdu_timeout); end
    tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.id_is_mdu = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_chk++; if (bus.pc_write !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d_pc_write got %b exp 0", i, bus.pc_write); end
      n_chk++; if (bus.mdu_timeout !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d_flag got %b exp 0", i, bus.mdu_timeout); end
      tick();
    end
    @(negedge clk);
    n_chk++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL to_rel_pc_write got %b exp 1", bus.pc_write); end
    n_chk++; if (bus.mdu_start !== 1'b0) begin n_fail++; $display("FAIL to_rel_start got %b exp 0", bus.mdu_start); end
    n_chk++; if (bus.mdu_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag got %b exp 1", bus.mdu_timeout); end
    n_chk++; if (bus.stall_count !== 4'd9) begin n_fail++; $display("FAIL to_stall got %0d exp 9", bus.stall_count); end
    tick();
    bus.id_is_mdu = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_chk++; if (bus.mdu_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b exp 1", bus.mdu_timeout); end
    tick();
    // done on the final allowed wait cycle wins over the timeout
    apply_reset();
    bus.id_is_mdu = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      bus.mdu_done = (i == 8);
      tick();
    end
    bus.mdu_done = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL tie_rel_pc_write got %b exp 1", bus.pc_write); end
    n_chk++; if (bus.mdu_timeout !== 1'b0) begin n_fail++; $display("FAIL tie_flag got %b exp 0", bus.mdu_timeout); end
    tick();
    bus.id_is_mdu = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.mdu_timeout !== 1'b0) begin n_fail++; $display("FAIL tie_flag_later got %b exp 0", bus.mdu_timeout); end
    tick();
  endtask

  task automatic test_saturation();
    apply_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rt = 5'd5; bus.id_use_rt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 14) begin
        @(negedge clk);
        n_chk++; if (bus.stall_count !== 4'd14) begin n_fail++; $display("FAIL sat_mid got %0d exp 14", bus.stall_count); end
      end
      tick();
    end
    quiet();
    @(negedge clk);
    n_chk++; if (bus.stall_count !== 4'd15) begin n_fail++; $display("FAIL sat_final got %0d exp 15", bus.stall_count); end
    tick();
  endtask

  task automatic test_reset_abort();
    int starts;
    apply_reset();
    bus.id_is_mdu = 1'b1;
    tick();
    repeat (3) tick();
    rst_n = 1'b0;
    starts = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.mdu_start === 1'b1) starts++;
      n_chk++; if (bus.ifid_flush !== 1'b1) begin n_fail++; $display("FAIL abort_flush got %b exp 1", bus.ifid_flush); end
      n_chk++; if (bus.stall_count !== 4'd0) begin n_fail++; $display("FAIL abort_stall got %0d exp 0", bus.stall_count); end
      tick();
    end
    quiet();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mdu_start === 1'b1) starts++;
      n_chk++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL abort_run%0d_pc_write got %b exp 1", i, bus.pc_write); end
      tick();
    end
    n_chk++; if (starts !== 0) begin n_fail++; $display("FAIL abort_starts got %0d exp 0", starts); end
    n_chk++; if (bus.stall_count !== 4'd0) begin n_fail++; $display("FAIL abort_final_stall got %0d exp 0", bus.stall_count); end
  endtask

  initial begin
    quiet();
    test_reset();
    test_load_use();
    test_branch();
    test_mdu();
    test_timeout();
    test_saturation();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
